// File: rtl/icache_lined.sv
// Direct-mapped instruction cache with multi-word lines, in-order line refill,
// whole-cache invalidate and redirect abort.
module icache_lined #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  localparam int TAG_W   = 32'sd30 - INDEX_W - OFFSET_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  input  logic        abort,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int LINES = 32'sd1 << INDEX_W;
  localparam int WORDS = 32'sd1 << OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_REFILL  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  function automatic logic parity32(input logic [31:0] word);
    return ^word;
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [29:0]             addr_r;
  logic [LINES-1:0]        valid_r;
  logic [TAG_W-1:0]        tag_r [LINES];
  logic [31:0]             data_r [LINES*WORDS];
  logic [LINES*WORDS-1:0]  par_r;
  logic [OFFSET_W-1:0]     beat_r;
  logic                    abort_r;
  logic                    flush_r;
  logic                    resp_valid_r;
  logic [31:0]             resp_inst_r;
  logic                    mem_req_r;
  logic [31:0]             mem_addr_r;

  logic [TAG_W-1:0]        tag_s;
  logic [INDEX_W-1:0]      idx_s;
  logic [OFFSET_W-1:0]     off_s;
  logic [29-OFFSET_W:0]    line_s;
  logic [31:0]             hit_word_s;
  logic                    par_ok_s;
  logic                    hit_s;
  logic                    last_beat_s;
  logic [OFFSET_W-1:0]     beat_nxt_s;
  logic                    refill_fire_s;
  logic                    addr_lo_unused_s;

  assign tag_s         = addr_r[29 -: TAG_W];
  assign idx_s         = addr_r[OFFSET_W +: INDEX_W];
  assign off_s         = addr_r[OFFSET_W-1:0];
  assign line_s        = addr_r[29:OFFSET_W];
  assign hit_word_s    = data_r[{idx_s, off_s}];
  assign par_ok_s      = (par_r[{idx_s, off_s}] == parity32(hit_word_s));
  // A flush in the lookup cycle wins over a hit; a corrupted word refetches.
  assign hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s) && par_ok_s && !flush;
  assign last_beat_s   = (beat_r == {OFFSET_W{1'b1}});
  assign beat_nxt_s    = beat_r + OFFSET_W'(1'b1);
  assign refill_fire_s = (state_r == ST_REFILL) && mem_valid;
  assign addr_lo_unused_s = ^req_addr[1:0];

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_inst  = resp_inst_r;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;

  // Next-state decode of the request/refill sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_nxt_s = ST_LOOKUP;
        else           state_nxt_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (abort)      state_nxt_s = ST_IDLE;
        else if (hit_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_valid && last_beat_s) state_nxt_s = ST_RESPOND;
        else                          state_nxt_s = ST_REFILL;
      end
      ST_RESPOND: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in)      state_r <= ST_IDLE;
    else if (rdy_in) state_r <= state_nxt_s;
  end

  // Line storage: data words with parity, and the tag, written as beats arrive.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && refill_fire_s) begin
      data_r[{idx_s, beat_r}] <= mem_data;
      par_r[{idx_s, beat_r}]  <= parity32(mem_data);
      if (last_beat_s) tag_r[idx_s] <= tag_s;
    end
  end

  // Control registers, valid bits, response and memory-request outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_r       <= 30'd0;
      valid_r      <= '0;
      beat_r       <= '0;
      abort_r      <= 1'b0;
      flush_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_inst_r  <= 32'd0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'd0;
    end else if (rdy_in) begin
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          abort_r <= 1'b0;
          if (req_valid) addr_r <= req_addr[31:2];
        end
        ST_LOOKUP: begin
          if (!abort) begin
            if (hit_s) begin
              resp_valid_r <= 1'b1;
              resp_inst_r  <= hit_word_s;
            end else begin
              valid_r[idx_s] <= 1'b0;
              beat_r         <= '0;
              mem_req_r      <= 1'b1;
              mem_addr_r     <= {line_s, {OFFSET_W{1'b0}}, 2'b00};
            end
          end
        end
        ST_REFILL: begin
          if (abort) abort_r <= 1'b1;
          if (flush) flush_r <= 1'b1;
          if (mem_valid) begin
            if (beat_r == off_s) resp_inst_r <= mem_data;
            beat_r <= beat_nxt_s;
            if (last_beat_s) begin
              mem_req_r <= 1'b0;
              flush_r   <= 1'b0;
              // A flush seen at any point of the refill leaves the line invalid.
              if (!(flush || flush_r)) valid_r[idx_s] <= 1'b1;
            end else begin
              mem_addr_r <= {line_s, beat_nxt_s, 2'b00};
            end
          end
        end
        ST_RESPOND: resp_valid_r <= !(abort_r || abort);
        default: ;
      endcase
      if (flush) valid_r <= '0;
    end
  end

endmodule

// File: tb/tb_icache_lined.sv
// Directed self-checking bench for icache_lined: a one-cycle memory model
// serves refills, and each fetch is checked for latency, data and beat addresses.
module tb_icache_lined;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        abort;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] beat_log[$];
  logic [31:0] drv_addr;

  localparam int INJ_NONE  = 0;
  localparam int INJ_ABORT = 1;
  localparam int INJ_FLUSH = 2;
  localparam int INJ_STALL = 3;

  icache_lined dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_inst (resp_inst),
    .abort     (abort),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory contents: 0xA0 + word offset, plus the line base relative to 0x1000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + ((a & 32'h0000_000F) >> 2) + ((a & 32'hFFFF_FFF0) - 32'h0000_1000);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle memory: answers every cycle mem_req is seen, logs consumed beats.
  initial begin
    mem_valid = 1'b0;
    mem_data  = 32'd0;
    drv_addr  = 32'd0;
    forever begin
      @(posedge clk_in);
      if (mem_valid && rdy_in && !rst_in) beat_log.push_back(drv_addr);
      @(negedge clk_in);
      if (mem_req) begin
        mem_valid = 1'b1;
        drv_addr  = mem_addr;
        mem_data  = mem_word(mem_addr);
      end else begin
        mem_valid = 1'b0;
      end
    end
  end

  task automatic do_fetch(input string tag, input logic [31:0] a, input bit exp_resp,
                          input logic [31:0] exp_inst, input int exp_lat, input int exp_beats,
                          input int inj_k, input int inj_kind);
    int          b0;
    int          lat;
    bit          seen;
    logic [31:0] inst;
    @(negedge clk_in);
    check_val({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    b0 = beat_log.size();
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk_in);
    req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    inst = 32'd0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk_in);
      abort  = (inj_kind == INJ_ABORT) && (k == inj_k);
      flush  = (inj_kind == INJ_FLUSH) && (k == inj_k);
      rdy_in = !((inj_kind == INJ_STALL) && (k >= inj_k) && (k < inj_k + 3));
      if ((inj_kind == INJ_STALL) && (k == inj_k + 2))
        check_val({tag, " stall addr"}, mem_addr, {a[31:4], 4'h4});
      if (resp_valid && !seen) begin
        seen = 1'b1;
        lat  = k + 1;
        inst = resp_inst;
      end
      if (exp_resp && seen) break;
    end
    abort  = 1'b0;
    flush  = 1'b0;
    rdy_in = 1'b1;
    if (exp_resp) begin
      check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, " inst"}, inst, exp_inst);
      @(negedge clk_in);
      check_val({tag, " pulse"}, {31'd0, resp_valid}, 32'd0);
    end else begin
      check_val({tag, " noresp"}, {31'd0, seen}, 32'd0);
    end
    check_val({tag, " beats"}, 32'(beat_log.size() - b0), 32'(exp_beats));
    if (exp_beats == 4 && beat_log.size() >= b0 + 4) begin
      for (int i = 0; i < 4; i++)
        check_val($sformatf("%s beat%0d addr", tag, i), beat_log[b0 + i],
                  {a[31:4], 4'h0} + 32'(4 * i));
    end
  endtask

  task automatic flush_idle();
    @(negedge clk_in);
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    abort     = 1'b0;
    flush     = 1'b0;
    repeat (3) @(negedge clk_in);
    check_val("rst req_ready",  {31'd0, req_ready},  32'd1);
    check_val("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst resp_inst",  resp_inst,           32'd0);
    check_val("rst mem_req",    {31'd0, mem_req},    32'd0);
    check_val("rst mem_addr",   mem_addr,            32'd0);
    rst_in = 1'b0;

    do_fetch("cold 1000",    32'h0000_1000, 1'b1, 32'h0000_00A0, 7, 4, 0, INJ_NONE);
    do_fetch("hit 1008",     32'h0000_1008, 1'b1, 32'h0000_00A2, 2, 0, 0, INJ_NONE);

    flush_idle();
    do_fetch("post-flush 1004", 32'h0000_1004, 1'b1, 32'h0000_00A1, 7, 4, 0, INJ_NONE);
    do_fetch("conflict 2008",   32'h0000_2008, 1'b1, 32'h0000_10A2, 7, 4, 0, INJ_NONE);
    do_fetch("conflict 100C",   32'h0000_100C, 1'b1, 32'h0000_00A3, 7, 4, 0, INJ_NONE);

    do_fetch("abort beat1 3004", 32'h0000_3004, 1'b0, 32'd0, 0, 4, 2, INJ_ABORT);
    do_fetch("rehit 3004",       32'h0000_3004, 1'b1, 32'h0000_20A1, 2, 0, 0, INJ_NONE);

    do_fetch("flush beat2 4010", 32'h0000_4010, 1'b1, 32'h0000_30B0, 7, 4, 3, INJ_FLUSH);
    do_fetch("remiss 4010",      32'h0000_4010, 1'b1, 32'h0000_30B0, 7, 4, 0, INJ_NONE);
    do_fetch("flushed 3004",     32'h0000_3004, 1'b1, 32'h0000_20A1, 7, 4, 0, INJ_NONE);

    do_fetch("stall 5028",        32'h0000_5028, 1'b1, 32'h0000_40C2, 10, 4, 2, INJ_STALL);
    do_fetch("flush lookup 5028", 32'h0000_5028, 1'b1, 32'h0000_40C2, 7, 4, 0, INJ_FLUSH);
    do_fetch("hit 5028",          32'h0000_5028, 1'b1, 32'h0000_40C2, 2, 0, 0, INJ_NONE);

    do_fetch("abort lookup 6000", 32'h0000_6000, 1'b0, 32'd0, 0, 0, 0, INJ_ABORT);

    // Reset in the middle of a refill withdraws the memory request.
    @(negedge clk_in);
    req_valid = 1'b1;
    req_addr  = 32'h0000_7000;
    @(negedge clk_in);
    req_valid = 1'b0;
    @(negedge clk_in);
    check_val("mid-refill mem_req", {31'd0, mem_req}, 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_val("rst refill mem_req",   {31'd0, mem_req},   32'd0);
    check_val("rst refill req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst refill mem_addr",  mem_addr,           32'd0);
    do_fetch("after rst 7000", 32'h0000_7000, 1'b1, 32'h0000_60A0, 7, 4, 0, INJ_NONE);
    do_fetch("after rst 1004", 32'h0000_1004, 1'b1, 32'h0000_00A1, 7, 4, 0, INJ_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_lined.md
# icache_lined

Parametrised direct-mapped instruction cache with multi-word lines and a built-in refill state machine. It sits between the instruction fetch unit and the memory arbiter. It serves one 32-bit instruction per accepted request. On a miss it refills a whole line from memory, one word at a time. It also supports whole-cache invalidation (`fence.i`) and request abort on redirect.

## Interface
- `INDEX_W`, default 4: line index bits; the cache holds 2^INDEX_W lines.
- `OFFSET_W`, default 2: word-offset bits; each line holds 2^OFFSET_W 32-bit words.
- `TAG_W`, derived as 30-INDEX_W-OFFSET_W: tag bits stored per line.
- `clk_in` in 1: clock. One clock; all state changes on the rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global enable. When low, all state is frozen and outputs hold.
- `req_valid` in 1: the fetch unit presents an address.
- `req_addr` in 32: fetch address. Bits [1:0] are ignored (word aligned).
- `req_ready` out 1: the cache can accept a request (state IDLE).
- `resp_valid` out 1: one-cycle pulse; `resp_inst` is valid.
- `resp_inst` out 32: the instruction.
- `abort` in 1: redirect. Drops the outstanding request's response.
- `flush` in 1: invalidate all lines.
- `mem_req` out 1: word read request to the arbiter. Held until `mem_valid`.
- `mem_addr` out 32: word address of the refill beat. Bits [1:0] are 0.
- `mem_valid` in 1: `mem_data` is valid and the current beat is complete.
- `mem_data` in 32: refill word.

## Operation
- Address split: tag = [31:2+INDEX_W+OFFSET_W], index = [1+INDEX_W+OFFSET_W:2+OFFSET_W], offset = [1+OFFSET_W:2].
- Per-line storage: valid bit, tag, and 2^OFFSET_W data words.
- States:
  - IDLE: `req_ready`=1.
  - LOOKUP: registered address is compared against the line.
  - REFILL: `mem_req`=1.
  - RESPOND.
- IDLE: on `req_valid`, latch the address and go to LOOKUP.
- LOOKUP on a hit (valid & tag match): drive `resp_valid`=1 with the word, return to IDLE.
- LOOKUP on a miss: clear the line's valid bit, set beat counter = 0, go to REFILL.
- REFILL:
  - `mem_addr` = {tag, index, beat, 2'b00}.
  - On each `mem_valid`, write `mem_data` into word[beat].
  - If beat == requested offset, also capture it into the response register.
  - Increment beat; the counter is OFFSET_W wide.
  - After the beat with counter = all-ones: set tag and valid, go to RESPOND.
- RESPOND: `resp_valid`=1 with the captured word, go to IDLE.
- Refill always fetches beats in order 0..N-1. Critical-word-first is not supported.
- `abort`:
  - In LOOKUP: the response is suppressed and the state goes to IDLE. A miss starts no refill.
  - In REFILL: the refill continues to completion and installs the line. RESPOND emits no `resp_valid`.
  - A sticky abort flag cleared in IDLE records this.
  - In IDLE: no effect.
- `flush`:
  - Clears all valid bits in the same cycle.
  - If it arrives during REFILL (or together with the last beat), the line under refill is not marked valid. The pending response is still delivered unless aborted.
  - A sticky flush flag, cleared on leaving REFILL, records this.
- Simultaneous `flush` and a LOOKUP hit: flush has priority. The lookup is treated as a miss.
- Simultaneous `req_valid` and `abort` in IDLE: the request is accepted. Abort applies only to an outstanding request.

## Timing
- Reset values:
  - state = IDLE; all valid bits = 0; beat = 0; abort/flush flags = 0.
  - `req_ready`=1 from the first cycle after reset.
  - `resp_valid`=0, `resp_inst`=0, `mem_req`=0, `mem_addr`=0.
- Reset mid-refill: the refill is abandoned and `mem_req` drops the next cycle. The arbiter must tolerate a withdrawn request.
- Hit latency: request accepted at edge T, `resp_valid` high in the cycle after T+1 (2 cycles request to response).
- Miss latency: 2 cycles plus the sum of N beat latencies plus 1, where N = 2^OFFSET_W. `mem_req` rises the cycle after LOOKUP.
- `mem_req`/`mem_addr` are registered. `mem_addr` changes only on the edge that consumes `mem_valid`. `mem_req` deasserts the cycle after the final beat.
- `rdy_in`=0 freezes state and counters; `mem_valid` is ignored. The arbiter must hold the beat.
- `resp_valid` is high for exactly one `rdy_in`-qualified cycle.
- Throughput: at most one request per 2 cycles on hits.

## Test plan
- Reset, then request 0x00001000 (cold) with 1-cycle memory returning 0xA0+beat per word:
  - 4 beats at addresses 0x1000, 0x1004, 0x1008, 0x100C.
  - `resp_inst` = the word for offset 0.
  - Total 7 cycles.
- Request 0x00001008 after the previous scenario:
  - Hit; `resp_valid` 2 cycles after accept with the beat-2 word.
  - `mem_req` stays 0.
- Request 0x00001000, then 0x00002000 (same index, different tag), then 0x00001000:
  - Three misses, each a refill.
  - Each response returns the correct word.
- Assert `abort` during beat 1 of a refill:
  - The line still completes.
  - No `resp_valid`.
  - A re-request of the same address hits in 2 cycles.
- Assert `flush` during beat 2:
  - The response is still delivered.
  - A re-request of the same address misses and refills.
  - After a `flush` in IDLE, all previously cached addresses miss.
- Hold `rdy_in`=0 for 3 cycles while `mem_valid`=1 mid-refill:
  - No beat is consumed and the beat counter is unchanged.
  - The refill resumes correctly on `rdy_in`=1.
